// File: rtl/body_pkg.sv
// Shared widths, body geometry and FSM encoding for vertex generation.
// Positions are Q10.8, radians Q2.7, trig values Q1.8.
package body_pkg;

    localparam int unsigned BODY_NUM  = 11;
    localparam int unsigned POS_W     = 19;
    localparam int unsigned POS_FRAC  = 8;
    localparam int unsigned RAD_W     = 10;
    localparam int unsigned RAD_FRAC  = 7;
    localparam int unsigned TRIG_W    = 10;
    localparam int unsigned TRIG_FRAC = 8;
    localparam int unsigned OFS_W     = 11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        DONE
    } state_t;

    // Half-width / half-height of each body's box, in whole pixels.
    localparam logic [9:0] HW [BODY_NUM] = '{10'd320, 10'd12, 10'd14, 10'd6, 10'd6, 10'd6,
                                             10'd50, 10'd6, 10'd6, 10'd50, 10'd0};
    localparam logic [9:0] HH [BODY_NUM] = '{10'd40, 10'd12, 10'd14, 10'd36, 10'd36, 10'd36,
                                             10'd6, 10'd30, 10'd30, 10'd6, 10'd0};

    // Corner order: 0 (-w,-h), 1 (+w,-h), 2 (+w,+h), 3 (-w,+h).
    function automatic void corner_offset(
        input  logic [3:0]              b,
        input  logic [1:0]              c,
        output logic signed [OFS_W-1:0] dx,
        output logic signed [OFS_W-1:0] dy
    );
        logic signed [OFS_W-1:0] w;
        logic signed [OFS_W-1:0] h;
        w = '0;
        h = '0;
        if (32'(b) < BODY_NUM) begin
            w = signed'({1'b0, HW[b]});
            h = signed'({1'b0, HH[b]});
        end
        dx = (c == 2'd0 || c == 2'd3) ? -w : w;
        dy = c[1] ? h : -h;
    endfunction

endpackage

// File: rtl/vertex_gen_trig_lut.sv
// Combinational sine/cosine of a Q2.7 radian, rounded to nearest Q1.8.
// Evaluated as a fixed-point series after folding the angle into [0, pi/2].
module trig_lut
    import body_pkg::*;
(
    input  logic signed [RAD_W-1:0]  rad,
    output logic signed [TRIG_W-1:0] sin_val,
    output logic signed [TRIG_W-1:0] cos_val
);

    localparam int unsigned     WF      = 24;
    localparam logic signed [63:0] ONE     = 64'sd16777216;
    localparam logic signed [63:0] HALF_PI = 64'sd26353589;
    localparam logic signed [63:0] PI      = 64'sd52707179;
    localparam logic signed [63:0] ROUND   = 64'sd1 <<< (WF - TRIG_FRAC - 1);
    // Reciprocals 1/(n(n+1)) in Q.24 for the Horner terms.
    localparam logic signed [63:0] R2  = 64'sd8388608;
    localparam logic signed [63:0] R6  = 64'sd2796203;
    localparam logic signed [63:0] R12 = 64'sd1398101;
    localparam logic signed [63:0] R20 = 64'sd838861;
    localparam logic signed [63:0] R30 = 64'sd559241;
    localparam logic signed [63:0] R42 = 64'sd399458;
    localparam logic signed [63:0] R56 = 64'sd299593;
    localparam logic signed [63:0] R72 = 64'sd233017;
    localparam logic signed [63:0] R90 = 64'sd186414;

    function automatic logic signed [63:0] mulq(input logic signed [63:0] a,
                                                input logic signed [63:0] b);
        return (a * b) >>> WF;
    endfunction

    logic signed [RAD_W:0]   mag;
    logic signed [63:0]      ang, t, t2, ps, pc;
    logic                    s_neg, c_neg;
    logic signed [TRIG_W-1:0] s_mag, c_mag;

    always_comb begin
        mag   = rad[RAD_W-1] ? -(11'(rad)) : 11'(rad);
        ang   = 64'(mag) <<< (WF - RAD_FRAC);
        s_neg = 1'b0;
        c_neg = 1'b0;
        if (ang <= HALF_PI) begin
            t = ang;
        end else if (ang <= PI) begin
            t     = PI - ang;
            c_neg = 1'b1;
        end else begin
            t     = ang - PI;
            s_neg = 1'b1;
            c_neg = 1'b1;
        end
        s_neg = s_neg ^ rad[RAD_W-1];
        t2 = mulq(t, t);

        ps = ONE - mulq(t2, R72);
        ps = ONE - mulq(mulq(t2, R42), ps);
        ps = ONE - mulq(mulq(t2, R20), ps);
        ps = ONE - mulq(mulq(t2, R6), ps);
        ps = mulq(t, ps);

        pc = ONE - mulq(t2, R90);
        pc = ONE - mulq(mulq(t2, R56), pc);
        pc = ONE - mulq(mulq(t2, R30), pc);
        pc = ONE - mulq(mulq(t2, R12), pc);
        pc = ONE - mulq(mulq(t2, R2), pc);

        if (ps < 0) ps = '0;
        if (pc < 0) pc = '0;
        s_mag   = 10'((ps + ROUND) >>> (WF - TRIG_FRAC));
        c_mag   = 10'((pc + ROUND) >>> (WF - TRIG_FRAC));
        sin_val = s_neg ? -s_mag : s_mag;
        cos_val = c_neg ? -c_mag : c_mag;
    end

endmodule

// File: rtl/vertex_gen.sv
// Walks all bodies, reads position/angle/alive, and writes the four rotated
// box corners of every alive body to the vertex store.
module vertex_gen
    import body_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [3:0]              body_nth,
    output logic                    pos_ren,
    output logic                    rad_ren,
    output logic                    alive_ren,
    input  logic signed [POS_W-1:0] pos_x_in,
    input  logic signed [POS_W-1:0] pos_y_in,
    input  logic signed [RAD_W-1:0] rad_in,
    input  logic                    alive_in,
    output logic [3:0]              vtx_nth,
    output logic [1:0]              vtx_i,
    output logic                    vtx_wen,
    output logic                    vtx_ren,
    output logic signed [POS_W-1:0] vtx_x_out,
    output logic signed [POS_W-1:0] vtx_y_out
);

    // Integer offset times Q1.8 trig already lands on the Q10.8 grid.
    localparam int unsigned ALIGN = TRIG_FRAC - POS_FRAC;

    state_t                   state, state_nx;
    logic [3:0]               body, body_nx;
    logic [1:0]               corner, corner_nx;
    logic                     advance;
    logic signed [POS_W-1:0]  pos_x, pos_y, vx, vy;
    logic signed [RAD_W-1:0]  rad;
    logic signed [TRIG_W-1:0] sin_v, cos_v;
    logic signed [OFS_W-1:0]  dx, dy;

    trig_lut u_trig (
        .rad     (rad),
        .sin_val (sin_v),
        .cos_val (cos_v)
    );

    always_comb corner_offset(body, corner, dx, dy);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            body   <= '0;
            corner <= '0;
            pos_x  <= '0;
            pos_y  <= '0;
            rad    <= '0;
            vx     <= '0;
            vy     <= '0;
        end else begin
            state  <= state_nx;
            body   <= body_nx;
            corner <= corner_nx;
            if (state == READ) begin
                pos_x <= pos_x_in;
                pos_y <= pos_y_in;
                rad   <= rad_in;
            end
            if (state == CALC) begin
                vx <= 19'(24'(pos_x) + ((24'(dx) * 24'(cos_v)) >>> ALIGN)
                                     - ((24'(dy) * 24'(sin_v)) >>> ALIGN));
                vy <= 19'(24'(pos_y) + ((24'(dx) * 24'(sin_v)) >>> ALIGN)
                                     + ((24'(dy) * 24'(cos_v)) >>> ALIGN));
            end
        end
    end

    always_comb begin
        state_nx  = state;
        body_nx   = body;
        corner_nx = corner;
        advance   = 1'b0;
        pos_ren   = 1'b0;
        rad_ren   = 1'b0;
        alive_ren = 1'b0;
        vtx_wen   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = READ;
                    body_nx   = '0;
                    corner_nx = '0;
                end
            end
            READ: begin
                pos_ren   = 1'b1;
                rad_ren   = 1'b1;
                alive_ren = 1'b1;
                if (alive_in) begin
                    state_nx  = CALC;
                    corner_nx = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            CALC: state_nx = WRITE;
            WRITE: begin
                vtx_wen = 1'b1;
                if (corner != 2'd3) begin
                    state_nx  = CALC;
                    corner_nx = corner + 2'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (advance) begin
            if (32'(body) < BODY_NUM - 1) begin
                state_nx = READ;
                body_nx  = body + 4'd1;
            end else begin
                state_nx = DONE;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign body_nth  = body;
    assign vtx_nth   = body;
    assign vtx_i     = corner;
    assign vtx_ren   = 1'b0;
    assign vtx_x_out = vtx_wen ? vx : '0;
    assign vtx_y_out = vtx_wen ? vy : '0;

endmodule

// File: tb/tb_vertex_gen.sv
// Scoreboard bench for vertex_gen: a behavioural storage model feeds the DUT,
// expected vertex writes are queued per pass and matched as the DUT writes.
module tb_vertex_gen;

    logic               clk = 1'b0;
    logic               rst, start;
    logic               busy, done;
    logic [3:0]         body_nth, vtx_nth;
    logic [1:0]         vtx_i;
    logic               pos_ren, rad_ren, alive_ren, vtx_wen, vtx_ren;
    logic signed [18:0] pos_x_in, pos_y_in, vtx_x_out, vtx_y_out;
    logic signed [9:0]  rad_in;
    logic               alive_in;

    vertex_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .body_nth  (body_nth),
        .pos_ren   (pos_ren),
        .rad_ren   (rad_ren),
        .alive_ren (alive_ren),
        .pos_x_in  (pos_x_in),
        .pos_y_in  (pos_y_in),
        .rad_in    (rad_in),
        .alive_in  (alive_in),
        .vtx_nth   (vtx_nth),
        .vtx_i     (vtx_i),
        .vtx_wen   (vtx_wen),
        .vtx_ren   (vtx_ren),
        .vtx_x_out (vtx_x_out),
        .vtx_y_out (vtx_y_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nth;
        int i;
        int x;
        int y;
    } exp_t;

    exp_t               sb[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 done_cnt, pass_writes, nth5_writes, first_nth, first_i;
    logic signed [18:0] mem_px [11];
    logic signed [18:0] mem_py [11];
    logic signed [9:0]  mem_rad [11];
    logic               mem_alive [11];
    int                 cap_x [11][4];
    int                 cap_y [11][4];
    int                 HW_T [11] = '{320, 12, 14, 6, 6, 6, 50, 6, 6, 50, 0};
    int                 HH_T [11] = '{40, 12, 14, 36, 36, 36, 6, 30, 30, 6, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Storage returns data only while the matching read enable is high.
    always_comb begin
        pos_x_in = '0;
        pos_y_in = '0;
        rad_in   = '0;
        alive_in = 1'b0;
        if (body_nth < 4'd11) begin
            if (pos_ren) begin
                pos_x_in = mem_px[body_nth];
                pos_y_in = mem_py[body_nth];
            end
            if (rad_ren)   rad_in   = mem_rad[body_nth];
            if (alive_ren) alive_in = mem_alive[body_nth];
        end
    end

    function automatic int rnd(real v);
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    // Avoid angles whose scaled trig value sits near a rounding midpoint.
    function automatic bit near_tie(int r);
        real a, s, c, fs, fc;
        a  = real'(r) / 128.0;
        s  = 256.0 * $sin(a);
        c  = 256.0 * $cos(a);
        fs = s - $floor(s);
        fc = c - $floor(c);
        return (fs > 0.45 && fs < 0.55) || (fc > 0.45 && fc < 0.55);
    endfunction

    function automatic exp_t model_vtx(int b, int c);
        exp_t               e;
        real                a;
        int                 s, co, dx, dy, px, py, sx, sy;
        logic signed [18:0] wx, wy;
        a  = real'(int'(mem_rad[b])) / 128.0;
        s  = rnd(256.0 * $sin(a));
        co = rnd(256.0 * $cos(a));
        dx = (c == 0 || c == 3) ? -HW_T[b] : HW_T[b];
        dy = (c < 2) ? -HH_T[b] : HH_T[b];
        px = mem_px[b];
        py = mem_py[b];
        sx = px + dx * co - dy * s;
        sy = py + dx * s + dy * co;
        wx = sx[18:0];
        wy = sy[18:0];
        e.nth = b;
        e.i   = c;
        e.x   = wx;
        e.y   = wy;
        return e;
    endfunction

    task automatic set_body(input int b, input int px, input int py, input int r, input bit alive);
        mem_px[b]    = 19'(px);
        mem_py[b]    = 19'(py);
        mem_rad[b]   = 10'(r);
        mem_alive[b] = alive;
    endtask

    task automatic rand_body(input int b, input bit alive);
        int r;
        do r = int'($urandom_range(0, 1023)) - 512; while (near_tie(r));
        set_body(b, int'($urandom_range(0, 400000)) - 200000,
                 int'($urandom_range(0, 400000)) - 200000, r, alive);
    endtask

    task automatic push_expected();
        for (int b = 0; b < 11; b++)
            if (mem_alive[b])
                for (int c = 0; c < 4; c++) sb.push_back(model_vtx(b, c));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) done_cnt++;
            check("vtx_ren", vtx_ren, 0);
            if (vtx_wen) begin
                pass_writes++;
                if (vtx_nth == 4'd5) nth5_writes++;
                if (pass_writes == 1) begin
                    first_nth = vtx_nth;
                    first_i   = vtx_i;
                end
                if (vtx_nth < 4'd11) begin
                    cap_x[vtx_nth][vtx_i] = vtx_x_out;
                    cap_y[vtx_nth][vtx_i] = vtx_y_out;
                end
                if (sb.size() == 0) begin
                    check("sb_extra_write", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("vtx_nth", vtx_nth, e.nth);
                    check("vtx_i", vtx_i, e.i);
                    check("vtx_x", vtx_x_out, e.x);
                    check("vtx_y", vtx_y_out, e.y);
                end
            end else begin
                check("vtx_x_idle", vtx_x_out, 0);
                check("vtx_y_idle", vtx_y_out, 0);
            end
        end
    end

    task automatic run_pass(input int exp_lat, input int exp_writes, input bit pulses);
        int t0, lat;
        bit got;
        push_expected();
        pass_writes = 0;
        nth5_writes = 0;
        done_cnt    = 0;
        first_nth   = -1;
        first_i     = -1;
        got         = 1'b0;
        lat         = -1;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        check("busy_before_accept", busy, 0);
        for (int k = 1; k <= 300 && !got; k++) begin
            @(negedge clk);
            start = pulses && (k == 10 || k == 50);
            if (k == 1) check("busy_after_accept", busy, 1);
            if (done) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        start = 1'b0;
        check("done_seen", got, 1);
        check("done_latency", lat, exp_lat);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_pulses", done_cnt, 1);
        check("write_count", pass_writes, exp_writes);
        check("sb_drained", sb.size(), 0);
        check("first_write_nth", first_nth, 0);
        check("first_write_i", first_i, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst   = 1'b1;
        start = 1'b0;
        for (int b = 0; b < 11; b++) set_body(b, 0, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pos_ren", pos_ren, 0);
        check("rst_rad_ren", rad_ren, 0);
        check("rst_alive_ren", alive_ren, 0);
        check("rst_vtx_wen", vtx_wen, 0);
        check("rst_vtx_ren", vtx_ren, 0);
        check("rst_body_nth", body_nth, 0);
        check("rst_vtx_nth", vtx_nth, 0);
        check("rst_vtx_i", vtx_i, 0);
        check("rst_vtx_x", vtx_x_out, 0);
        check("rst_vtx_y", vtx_y_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All alive, directed b0..b2.
        for (int b = 3; b < 11; b++) rand_body(b, 1'b1);
        set_body(0, 320 * 256, 440 * 256, 0, 1'b1);
        set_body(1, 130 * 256, 310 * 256, 0, 1'b1);
        set_body(2, 450 * 256, 390 * 256, 201, 1'b1);
        run_pass(100, 44, 1'b0);
        check("b1_i0_x", cap_x[1][0], 118 * 256);
        check("b1_i0_y", cap_y[1][0], 298 * 256);
        check("b1_i1_x", cap_x[1][1], 142 * 256);
        check("b1_i1_y", cap_y[1][1], 298 * 256);
        check("b1_i2_x", cap_x[1][2], 142 * 256);
        check("b1_i2_y", cap_y[1][2], 322 * 256);
        check("b1_i3_x", cap_x[1][3], 118 * 256);
        check("b1_i3_y", cap_y[1][3], 322 * 256);
        check("b2_i0_x", cap_x[2][0], 464 * 256);
        check("b2_i0_y", cap_y[2][0], 376 * 256);
        check("b0_i0_x", cap_x[0][0], 0);
        check("b0_i0_y", cap_y[0][0], 400 * 256);
        check("b0_i2_x", cap_x[0][2], 640 * 256);
        check("b0_i2_y", cap_y[0][2], 480 * 256);

        // Body 5 dead, stray starts mid-pass.
        for (int b = 0; b < 11; b++) rand_body(b, 1'b1);
        mem_alive[5] = 1'b0;
        run_pass(92, 40, 1'b1);
        check("no_b5_writes", nth5_writes, 0);

        // 19-bit wrap on b0 corner 1, two more dead bodies.
        for (int b = 0; b < 11; b++) rand_body(b, 1'b1);
        set_body(0, 1000 * 256 + 128, 10 * 256, 0, 1'b1);
        mem_alive[3]  = 1'b0;
        mem_alive[10] = 1'b0;
        run_pass(84, 36, 1'b0);
        check("wrap_b0_i1_x", cap_x[0][1], -186240);

        // Reset during body 4's first CALC cycle.
        for (int b = 0; b < 11; b++) rand_body(b, 1'b1);
        push_expected();
        pass_writes = 0;
        hit         = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && vtx_nth == 4'd4 && !pos_ren && !vtx_wen && !done) hit = 1'b1;
        end
        check("abort_point_seen", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_vtx_wen", vtx_wen, 0);
        check("abort_body_nth", body_nth, 0);
        check("abort_writes", pass_writes, 16);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        run_pass(100, 44, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
